// File: rtl/step_clock_ctrl.sv
// Run/single-step controller for the mips core: conditions the change/step buttons
// and drives a registered clock-enable, mode, sticky halt and retired-cycle count.
module step_clock_ctrl #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             change,
   input  logic             step,
   input  logic             halt,
   output logic             cpu_en,
   output logic             run_mode,
   output logic             halted,
   output logic [CNT_W-1:0] cycle_count
);

   localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      RUN,
      STEP_IDLE,
      STEP_FIRE,
      HALTED
   } state_t;

   // Button lanes: bit 0 = change, bit 1 = step.
   logic [1:0]      raw;
   logic [1:0]      sync1_q, sync1_d;
   logic [1:0]      sync2_q, sync2_d;
   logic [1:0]      level_q, level_d;
   logic [1:0]      prev_q, prev_d;
   logic [DB_W-1:0] db_cnt_q [2];
   logic [DB_W-1:0] db_cnt_d [2];
   logic [1:0]      press;

   state_t          state_q, state_d;
   logic            cpu_en_q, cpu_en_d;
   logic            run_mode_q, run_mode_d;
   logic            halted_q, halted_d;
   logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

   assign raw = {step, change};

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      sync1_d = raw;
      sync2_d = sync1_q;
      level_d = level_q;
      prev_d  = level_q;
      for (int i = 0; i < 2; i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != level_q[i]) begin
            // Accept the new level on the sample that would complete the stable run.
            if (db_cnt_q[i] == DB_LAST) begin
               level_d[i] = ~level_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
         end
      end
      press = level_q & ~prev_q;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN: begin
            if (halt)          state_d = HALTED;
            else if (press[0]) state_d = STEP_IDLE;
         end
         STEP_IDLE: begin
            if (halt)          state_d = HALTED;
            else if (press[0]) state_d = RUN;
            else if (press[1]) state_d = STEP_FIRE;
         end
         STEP_FIRE: begin
            if (halt)          state_d = HALTED;
            else if (press[0]) state_d = RUN;
            else               state_d = STEP_IDLE;
         end
         HALTED:               state_d = HALTED;
         default:              state_d = RUN;
      endcase

      // Outputs are decoded from the next state so they leave a flop aligned with the state.
      cpu_en_d      = (state_d == RUN) || (state_d == STEP_FIRE);
      run_mode_d    = (state_d == RUN);
      halted_d      = (state_d == HALTED);
      cycle_count_d = cycle_count_q + CNT_W'(cpu_en_q);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clock) begin
      if (!reset) begin
         sync1_q       <= '0;
         sync2_q       <= '0;
         level_q       <= '0;
         prev_q        <= '0;
         // NOTE: the two-entry counter array is plain flops, so it is reset explicitly like any register.
         db_cnt_q[0]   <= '0;
         db_cnt_q[1]   <= '0;
         state_q       <= RUN;
         cpu_en_q      <= 1'b0;
         run_mode_q    <= 1'b1;
         halted_q      <= 1'b0;
         cycle_count_q <= '0;
      end else begin
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         level_q       <= level_d;
         prev_q        <= prev_d;
         db_cnt_q[0]   <= db_cnt_d[0];
         db_cnt_q[1]   <= db_cnt_d[1];
         state_q       <= state_d;
         cpu_en_q      <= cpu_en_d;
         run_mode_q    <= run_mode_d;
         halted_q      <= halted_d;
         cycle_count_q <= cycle_count_d;
      end
   end

   assign cpu_en      = cpu_en_q;
   assign run_mode    = run_mode_q;
   assign halted      = halted_q;
   assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_step_clock_ctrl.sv
// Directed bench for step_clock_ctrl: an 8-bit-count instance for the main flow and a
// 4-bit-count instance for wrap-around; step pulses are matched against a queue.
module tb_step_clock_ctrl;

   logic       clock;
   logic       reset;
   logic       change;
   logic       step;
   logic       halt;
   logic       cpu_en, run_mode, halted;
   logic [7:0] cycle_count;
   logic       cpu_en_s, run_mode_s, halted_s;
   logic [3:0] cycle_count_s;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   logic [31:0] exp_q[$];
   logic        chk_width = 1'b0;

   step_clock_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
      .clock(clock), .reset(reset), .change(change), .step(step), .halt(halt),
      .cpu_en(cpu_en), .run_mode(run_mode), .halted(halted), .cycle_count(cycle_count)
   );

   step_clock_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut_small (
      .clock(clock), .reset(reset), .change(change), .step(step), .halt(halt),
      .cpu_en(cpu_en_s), .run_mode(run_mode_s), .halted(halted_s), .cycle_count(cycle_count_s)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Every single-step pulse must match a queued expectation and last exactly one cycle.
   always @(negedge clock) begin
      if (chk_width) begin
         check("step_pulse_width", 32'(cpu_en), 0);
         chk_width = 1'b0;
      end
      if (cpu_en === 1'b1 && run_mode === 1'b0) begin
         if (exp_q.size() == 0) begin
            check("unexpected_step_pulse", 32'(cpu_en), 0);
         end else begin
            check("step_pulse_count", 32'(cycle_count), exp_q.pop_front());
            chk_width = 1'b1;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset  = 1'b0;
      change = 1'b0;
      step   = 1'b0;
      halt   = 1'b0;
      tick(3);
      check("rst_cpu_en",   32'(cpu_en), 0);
      check("rst_run_mode", 32'(run_mode), 1);
      check("rst_halted",   32'(halted), 0);
      check("rst_count",    32'(cycle_count), 0);
      check("rst_count_s",  32'(cycle_count_s), 0);

      // Free run after reset release.
      reset = 1'b1;
      tick(1);
      check("first_cpu_en", 32'(cpu_en), 1);
      check("first_count",  32'(cycle_count), 0);
      tick(10);
      check("run10_count",  32'(cycle_count), 10);
      check("run10_mode",   32'(run_mode), 1);
      tick(7);
      check("run17_count",  32'(cycle_count), 17);
      check("wrap_count_s", 32'(cycle_count_s), 1);

      // change held 10 cycles: mode drops exactly 7 edges later.
      change = 1'b1;
      tick(6);
      check("change_lat_early", 32'(run_mode), 1);
      tick(1);
      check("change_lat_mode",   32'(run_mode), 0);
      check("change_lat_cpu_en", 32'(cpu_en), 0);
      check("change_lat_count",  32'(cycle_count), 24);
      tick(3);
      change = 1'b0;
      tick(10);
      check("step_idle_frozen", 32'(cycle_count), 24);
      check("step_idle_mode",   32'(run_mode), 0);

      // Three debounced step presses, one pulse each.
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(32'(24 + i));
         step = 1'b1;
         tick(10);
         step = 1'b0;
         tick(10);
      end
      check("steps_count",     32'(cycle_count), 27);
      check("steps_queue_empty", 32'(exp_q.size()), 0);

      // Short glitches must not fire a step.
      for (int i = 0; i < 3; i++) begin
         step = 1'b1;
         tick(3);
         step = 1'b0;
         tick(8);
      end
      check("glitch_count",  32'(cycle_count), 27);
      check("glitch_cpu_en", 32'(cpu_en), 0);

      // change and step together: change wins, the step is discarded.
      change = 1'b1;
      step   = 1'b1;
      tick(7);
      check("coincident_mode",  32'(run_mode), 1);
      check("coincident_count", 32'(cycle_count), 27);
      tick(3);
      change = 1'b0;
      step   = 1'b0;
      tick(10);
      check("coincident_run_count", 32'(cycle_count), 40);
      check("coincident_cpu_en",    32'(cpu_en), 1);

      // Fresh reset, run to 0x20, then a one-cycle halt.
      reset = 1'b0;
      tick(1);
      reset = 1'b1;
      tick(1);
      tick(32);
      check("pre_halt_count", 32'(cycle_count), 32'h20);
      halt = 1'b1;
      tick(1);
      halt = 1'b0;
      check("halt_flag",   32'(halted), 1);
      check("halt_cpu_en", 32'(cpu_en), 0);
      check("halt_count",  32'(cycle_count), 32'h21);
      check("halt_mode",   32'(run_mode), 0);
      change = 1'b1;
      step   = 1'b1;
      tick(10);
      change = 1'b0;
      step   = 1'b0;
      tick(10);
      check("halt_sticky",       32'(halted), 1);
      check("halt_btn_cpu_en",   32'(cpu_en), 0);
      check("halt_btn_count",    32'(cycle_count), 32'h21);

      reset = 1'b0;
      tick(1);
      check("rst2_cpu_en",   32'(cpu_en), 0);
      check("rst2_run_mode", 32'(run_mode), 1);
      check("rst2_halted",   32'(halted), 0);
      check("rst2_count",    32'(cycle_count), 0);
      reset = 1'b1;
      tick(1);
      check("rst2_release_cpu_en", 32'(cpu_en), 1);
      tick(2);
      check("final_queue_empty", 32'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
